// File: rtl/dcmac_segmenter.sv
// dcmac_segmenter: splits a 512-bit AXI stream into four lockstep 128-bit segments with ena/mty
// sideband and cuts packets longer than MAX_PACKET_SIZE. Optional counters: SEGMENTER_STATS_EN.
module dcmac_segmenter #(
    parameter int MAX_PACKET_SIZE = 16384
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [511:0] axis_in_tdata,
    input  logic [63:0]  axis_in_tkeep,
    input  logic         axis_in_tlast,
    input  logic         axis_in_tvalid,
    output logic         axis_in_tready,
    output logic [127:0] axis0_out_tdata,
    output logic [127:0] axis1_out_tdata,
    output logic [127:0] axis2_out_tdata,
    output logic [127:0] axis3_out_tdata,
    output logic [4:0]   axis0_out_tuser,
    output logic [4:0]   axis1_out_tuser,
    output logic [4:0]   axis2_out_tuser,
    output logic [4:0]   axis3_out_tuser,
    output logic         axis0_out_tlast,
    output logic         axis1_out_tlast,
    output logic         axis2_out_tlast,
    output logic         axis3_out_tlast,
    output logic         axis0_out_tvalid,
    output logic         axis1_out_tvalid,
    output logic         axis2_out_tvalid,
    output logic         axis3_out_tvalid,
    input  logic         axis0_out_tready,
    input  logic         axis1_out_tready,
    input  logic         axis2_out_tready,
    input  logic         axis3_out_tready,
    output logic         pkt_truncated,
`ifdef SEGMENTER_STATS_EN
    output logic [31:0]  stat_packets,
    output logic [31:0]  stat_truncated,
    output logic [31:0]  stat_empty_last,
`endif
    output logic         dbg_state_o
);

    localparam int MAX_BEATS = MAX_PACKET_SIZE / 64;
    localparam int CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1. Valid,
    // once raised, holds its payload until accepted; the output side is ready only when all four
    // segment readies are 1, and input ready comes from a register, never from output ready.

    typedef enum logic {
        S_PASS    = 1'b0,
        S_DISCARD = 1'b1
    } state_t;

    typedef struct packed {
        logic [511:0] data;
        logic [19:0]  user;   // segment N sideband at [5N+4:5N]
        logic         last;
    } beat_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    beat_t              main_q, main_d;
    beat_t              skid_q, skid_d;
    logic               main_valid_q, main_valid_d;
    logic               skid_valid_q, skid_valid_d;
    logic               tready_q, tready_d;
    logic               trunc_q, trunc_d;

    beat_t              fmt;
    logic               out_ready;
    logic               drain;
    logic               in_fire;
    logic               pass_fire;
    logic               at_limit;

    function automatic logic [4:0] seg_user(input logic [15:0] k);
        logic [3:0] hi;
        hi = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (k[i]) hi = 4'(i);
        end
        return {|k, (|k) ? (4'd15 - hi) : 4'd0};
    endfunction

    assign out_ready = axis0_out_tready & axis1_out_tready & axis2_out_tready & axis3_out_tready;
    assign drain     = main_valid_q & out_ready;
    assign in_fire   = axis_in_tvalid & tready_q;
    assign pass_fire = in_fire & (state_q == S_PASS);
    assign at_limit  = (cnt_q == CNT_W'(MAX_BEATS - 1));

    always_comb begin
        fmt.data = axis_in_tdata;
        fmt.user = '0;
        fmt.last = axis_in_tlast | at_limit;
        for (int n = 0; n < 4; n++) begin
            fmt.user[5*n +: 5] = seg_user(axis_in_tkeep[16*n +: 16]);
        end
    end

    // Main register feeds the outputs; the skid register absorbs the one beat that can arrive
    // after output ready drops, because input ready only reacts a cycle later.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (drain) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = 1'b0;
            end
        end
        if (pass_fire) begin
            if (!main_valid_d) begin
                main_d       = fmt;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = fmt;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trunc_d = 1'b0;
        case (state_q)
            S_PASS: begin
                if (pass_fire) begin
                    if (axis_in_tlast) begin
                        cnt_d = '0;
                    end else if (at_limit) begin
                        cnt_d   = '0;
                        trunc_d = 1'b1;
                        state_d = S_DISCARD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DISCARD: begin
                if (in_fire && axis_in_tlast) begin
                    state_d = S_PASS;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_PASS;
                cnt_d   = '0;
            end
        endcase
        tready_d = (state_d == S_DISCARD) || !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_PASS;
            cnt_q        <= '0;
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            tready_q     <= 1'b0;
            trunc_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            tready_q     <= tready_d;
            trunc_q      <= trunc_d;
        end
    end

`ifdef SEGMENTER_STATS_EN
    logic [31:0] stat_packets_q, stat_truncated_q, stat_empty_last_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stat_packets_q    <= '0;
            stat_truncated_q  <= '0;
            stat_empty_last_q <= '0;
        end else begin
            if (drain && main_q.last) stat_packets_q <= stat_packets_q + 32'd1;
            if (trunc_q) stat_truncated_q <= stat_truncated_q + 32'd1;
            if (pass_fire && axis_in_tlast && (axis_in_tkeep == '0))
                stat_empty_last_q <= stat_empty_last_q + 32'd1;
        end
    end

    assign stat_packets    = stat_packets_q;
    assign stat_truncated  = stat_truncated_q;
    assign stat_empty_last = stat_empty_last_q;
`endif

    assign axis_in_tready   = tready_q;
    assign pkt_truncated    = trunc_q;
    assign dbg_state_o      = (state_q == S_DISCARD);

    assign axis0_out_tdata  = main_q.data[127:0];
    assign axis1_out_tdata  = main_q.data[255:128];
    assign axis2_out_tdata  = main_q.data[383:256];
    assign axis3_out_tdata  = main_q.data[511:384];
    assign axis0_out_tuser  = main_q.user[4:0];
    assign axis1_out_tuser  = main_q.user[9:5];
    assign axis2_out_tuser  = main_q.user[14:10];
    assign axis3_out_tuser  = main_q.user[19:15];
    assign axis0_out_tlast  = main_q.last;
    assign axis1_out_tlast  = main_q.last;
    assign axis2_out_tlast  = main_q.last;
    assign axis3_out_tlast  = main_q.last;
    assign axis0_out_tvalid = main_valid_q;
    assign axis1_out_tvalid = main_valid_q;
    assign axis2_out_tvalid = main_valid_q;
    assign axis3_out_tvalid = main_valid_q;

endmodule

// File: tb/tb_dcmac_segmenter.sv
// Directed bench for dcmac_segmenter built with MAX_PACKET_SIZE=256 (four beats per packet).
module tb_dcmac_segmenter;
  localparam int W = 533;  // {data[511:0], user[19:0], last}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic [511:0]  tdata;
  logic [63:0]   tkeep;
  logic          tlast;
  logic          tvalid;
  logic          tready;
  logic [3:0]    seg_ready;
  logic [127:0]  o_tdata [4];
  logic [4:0]    o_tuser [4];
  logic          o_tlast [4];
  logic          o_tvalid [4];
  logic          pkt_truncated;
  logic          dbg_state;
`ifdef SEGMENTER_STATS_EN
  logic [31:0]   stat_packets, stat_truncated, stat_empty_last;
`endif

  int checks = 0;
  int errors = 0;
  int trunc_seen = 0;
  int seg_diverge = 0;
  int cyc = 0;
  bit bp_mode = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  dcmac_segmenter #(.MAX_PACKET_SIZE(256)) dut (
    .clk(clk), .resetn(resetn),
    .axis_in_tdata(tdata), .axis_in_tkeep(tkeep), .axis_in_tlast(tlast),
    .axis_in_tvalid(tvalid), .axis_in_tready(tready),
    .axis0_out_tdata(o_tdata[0]), .axis1_out_tdata(o_tdata[1]),
    .axis2_out_tdata(o_tdata[2]), .axis3_out_tdata(o_tdata[3]),
    .axis0_out_tuser(o_tuser[0]), .axis1_out_tuser(o_tuser[1]),
    .axis2_out_tuser(o_tuser[2]), .axis3_out_tuser(o_tuser[3]),
    .axis0_out_tlast(o_tlast[0]), .axis1_out_tlast(o_tlast[1]),
    .axis2_out_tlast(o_tlast[2]), .axis3_out_tlast(o_tlast[3]),
    .axis0_out_tvalid(o_tvalid[0]), .axis1_out_tvalid(o_tvalid[1]),
    .axis2_out_tvalid(o_tvalid[2]), .axis3_out_tvalid(o_tvalid[3]),
    .axis0_out_tready(seg_ready[0]), .axis1_out_tready(seg_ready[1]),
    .axis2_out_tready(seg_ready[2]), .axis3_out_tready(seg_ready[3]),
    .pkt_truncated(pkt_truncated),
`ifdef SEGMENTER_STATS_EN
    .stat_packets(stat_packets), .stat_truncated(stat_truncated),
    .stat_empty_last(stat_empty_last),
`endif
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Output monitor: records every output transfer and segment consistency.
  always @(negedge clk) begin
    if (o_tvalid[0] === 1'b1 && seg_ready === 4'hF)
      obs_q.push_back({o_tdata[3], o_tdata[2], o_tdata[1], o_tdata[0],
                       o_tuser[3], o_tuser[2], o_tuser[1], o_tuser[0], o_tlast[0]});
    if (pkt_truncated === 1'b1) trunc_seen++;
    for (int n = 1; n < 4; n++)
      if (o_tvalid[n] !== o_tvalid[0] || o_tlast[n] !== o_tlast[0]) seg_diverge++;
  end

  // Reference formatting: count zero bytes down from the top of each keep slice.
  function automatic logic [W-1:0] exp_beat(input logic [511:0] d, input logic [63:0] k,
                                            input logic l);
    logic [19:0] u;
    logic [15:0] s;
    logic [3:0]  z;
    bit          found;
    u = '0;
    for (int n = 0; n < 4; n++) begin
      s = k[16*n +: 16];
      z = 4'd0;
      found = 1'b0;
      for (int i = 15; i >= 0; i--) begin
        if (!found) begin
          if (s[i]) found = 1'b1;
          else z = z + 4'd1;
        end
      end
      if (found) u[5*n +: 5] = {1'b1, z};
    end
    return {d, u, l};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
    bit done;
    done = 1'b0;
    tdata = d;
    tkeep = k;
    tlast = l;
    tvalid = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      if (bp_mode)
        for (int b = 0; b < 4; b++) seg_ready[b] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (tready === 1'b1) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got tready low for 100 cycles, expected acceptance");
    end
  endtask

  task automatic drain(input int limit);
    for (int t = 0; t < limit && obs_q.size() < exp_q.size(); t++) idle(1);
  endtask

  // Compare observed beats against the expected queue, one comparison per beat.
  task automatic compare_queues(input string name);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d beats, expected %0d", name, obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [W-1:0] o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s_beat: got %h expected %h", name, o, e);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if ({o_tvalid[n], o_tlast[n], o_tuser[n], o_tdata[n]} !== '0) begin
        errors++;
        $display("FAIL reset_seg%0d: got valid=%b last=%b user=%h data=%h, expected all 0",
                 n, o_tvalid[n], o_tlast[n], o_tuser[n], o_tdata[n]);
      end
    end
    checks++;
    if (tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_tready: got %b expected 0", tready);
    end
    checks++;
    if (pkt_truncated !== 1'b0) begin
      errors++;
      $display("FAIL reset_trunc: got %b expected 0", pkt_truncated);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(2);
    checks++;
    if (tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_tready: got %b expected 1", tready);
    end
  endtask

  task automatic test_single;
    logic [511:0] d;
    for (int k = 0; k < 64; k++) d[8*k +: 8] = 8'(k);
    obs_q.delete();
    exp_q.delete();
    trunc_seen = 0;
    send_beat(d, '1, 1'b1);
    tvalid = 1'b0;
    checks++;
    if (o_tvalid[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: got valid=%b one cycle after accept, expected 1", o_tvalid[0]);
    end
    checks++;
    if (o_tdata[3][127:120] !== 8'd63 || o_tdata[0][7:0] !== 8'd0) begin
      errors++;
      $display("FAIL single_bytes: got seg3 top=%h seg0 low=%h, expected 3f 00",
               o_tdata[3][127:120], o_tdata[0][7:0]);
    end
    exp_q.push_back({d, {4{5'h10}}, 1'b1});
    idle(3);
    compare_queues("single");
  endtask

  task automatic test_short_last;
    logic [511:0] d1, d2, d3, d4;
    d1 = {64{8'h11}};
    d2 = {64{8'h22}};
    d3 = {64{8'h33}};
    d4 = {64{8'h44}};
    obs_q.delete();
    send_beat(d1, '1, 1'b0);
    send_beat(d2, 64'h0000_0000_000F_FFFF, 1'b1);
    send_beat(d3, 64'h0, 1'b1);
    send_beat(d4, {16'h0001, 16'h8001, 16'h0100, 16'hFFFF}, 1'b1);
    tvalid = 1'b0;
    exp_q.push_back({d1, {4{5'h10}}, 1'b0});
    exp_q.push_back({d2, 5'h00, 5'h00, 5'h1C, 5'h10, 1'b1});
    exp_q.push_back({d3, 20'h0, 1'b1});
    exp_q.push_back({d4, 5'h1F, 5'h10, 5'h17, 5'h10, 1'b1});
    drain(10);
    compare_queues("short");
  endtask

  task automatic test_oversize;
    obs_q.delete();
    trunc_seen = 0;
    for (int i = 0; i < 6; i++) begin
      send_beat({64{8'(8'hA0 + i)}}, '1, (i == 5));
      if (i == 3) begin
        checks++;
        if (pkt_truncated !== 1'b1 || dbg_state !== 1'b1) begin
          errors++;
          $display("FAIL oversize_pulse: got trunc=%b state=%b, expected 1 1",
                   pkt_truncated, dbg_state);
        end
      end
    end
    send_beat({64{8'hB0}}, '1, 1'b1);
    tvalid = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back({{64{8'(8'hA0 + i)}}, {4{5'h10}}, (i == 3)});
    exp_q.push_back({{64{8'hB0}}, {4{5'h10}}, 1'b1});
    drain(10);
    idle(2);
    checks++;
    if (trunc_seen !== 1) begin
      errors++;
      $display("FAIL oversize_trunc_count: got %0d pulses expected 1", trunc_seen);
    end
    compare_queues("oversize");
  endtask

  task automatic test_exact;
    obs_q.delete();
    trunc_seen = 0;
    for (int i = 0; i < 4; i++) send_beat({64{8'(8'hC0 + i)}}, '1, (i == 3));
    for (int i = 0; i < 2; i++) send_beat({64{8'(8'hD0 + i)}}, '1, (i == 1));
    tvalid = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back({{64{8'(8'hC0 + i)}}, {4{5'h10}}, (i == 3)});
    for (int i = 0; i < 2; i++) exp_q.push_back({{64{8'(8'hD0 + i)}}, {4{5'h10}}, (i == 1)});
    drain(10);
    idle(2);
    checks++;
    if (trunc_seen !== 0) begin
      errors++;
      $display("FAIL exact_trunc_count: got %0d pulses expected 0", trunc_seen);
    end
    compare_queues("exact");
  endtask

  task automatic test_back_pressure;
    int left, plen, t0, t1;
    logic [511:0] d;
    logic [63:0] k;
    int sh;
    obs_q.delete();
    exp_q.delete();
    trunc_seen = 0;
    seg_diverge = 0;
    bp_mode = 1'b1;
    left = 1000;
    while (left > 0) begin
      plen = $urandom_range(1, 4);
      if (plen > left) plen = left;
      for (int b = 0; b < plen; b++) begin
        for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom;
        k = '1;
        if (b == plen - 1) begin
          sh = $urandom_range(0, 64);
          k = (sh == 64) ? 64'h0 : ({64{1'b1}} >> sh);
        end
        exp_q.push_back(exp_beat(d, k, (b == plen - 1)));
        send_beat(d, k, (b == plen - 1));
      end
      left -= plen;
    end
    bp_mode = 1'b0;
    tvalid = 1'b0;
    seg_ready = 4'hF;
    drain(50);
    t0 = cyc;
    for (int i = 0; i < 50; i++) begin
      for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom;
      exp_q.push_back(exp_beat(d, '1, 1'b1));
      send_beat(d, '1, 1'b1);
    end
    t1 = cyc;
    tvalid = 1'b0;
    checks++;
    if (t1 - t0 !== 50) begin
      errors++;
      $display("FAIL throughput: got %0d cycles for 50 beats, expected 50", t1 - t0);
    end
    drain(20);
    checks++;
    if (seg_diverge !== 0 || trunc_seen !== 0) begin
      errors++;
      $display("FAIL bp_lockstep: got diverge=%0d trunc=%0d, expected 0 0", seg_diverge, trunc_seen);
    end
    compare_queues("bp");
  endtask

  task automatic test_reset_mid;
    send_beat({64{8'hE5}}, '1, 1'b0);
    tdata = {64{8'hE6}};
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if ({o_tvalid[n], o_tlast[n], o_tuser[n], o_tdata[n]} !== '0) begin
        errors++;
        $display("FAIL midreset_seg%0d: got valid=%b last=%b user=%h data=%h, expected all 0",
                 n, o_tvalid[n], o_tlast[n], o_tuser[n], o_tdata[n]);
      end
    end
    checks++;
    if (tready !== 1'b0 || pkt_truncated !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ctrl: got tready=%b trunc=%b expected 0 0", tready, pkt_truncated);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    tvalid = 1'b0;
    idle(1);
    obs_q.delete();
    exp_q.delete();
    trunc_seen = 0;
    for (int i = 0; i < 4; i++) send_beat({64{8'(8'hF0 + i)}}, '1, (i == 3));
    tvalid = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back({{64{8'(8'hF0 + i)}}, {4{5'h10}}, (i == 3)});
    drain(10);
    idle(2);
    checks++;
    if (trunc_seen !== 0) begin
      errors++;
      $display("FAIL midreset_trunc: got %0d pulses expected 0", trunc_seen);
    end
    compare_queues("midreset");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    resetn = 1'b0;
    tdata = '0;
    tkeep = '0;
    tlast = 1'b0;
    tvalid = 1'b0;
    seg_ready = 4'hF;
    test_reset();
    test_single();
    test_short_last();
    test_oversize();
    test_exact();
    test_back_pressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
